// File: rtl/lbg_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the LBG codebook block.
package lbg_pkg;

  localparam int DW        = 14;
  localparam int DIM       = 13;
  localparam int CB_MAX    = 16;
  localparam int EPS_SHIFT = 5;
  localparam int CB_WORDS  = CB_MAX * DIM;
  localparam int AW        = 8;

  localparam logic [3:0] LAST_DIM = 4'(DIM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SPLIT_RD,
    ST_SPLIT_WR,
    ST_DONE
  } lbg_state_t;

  // Flat array address of coefficient dim of codeword idx.
  function automatic logic [AW-1:0] cb_addr(input logic [3:0] idx, input logic [3:0] dim);
    return AW'(idx) * AW'(DIM) + AW'(dim);
  endfunction

  // v*(1+eps) when plus is set, v*(1-eps) otherwise; the shift floors toward
  // -inf and the result is clamped to the signed DW-bit range.
  function automatic logic signed [DW-1:0] sat_eps(input logic signed [DW-1:0] v,
                                                   input logic plus);
    logic signed [DW:0] ext;
    logic signed [DW:0] sh;
    logic signed [DW:0] sum;
    ext = {v[DW-1], v};
    sh  = ext >>> EPS_SHIFT;
    sum = plus ? (ext + sh) : (ext - sh);
    if (sum[DW] != sum[DW-1])
      sat_eps = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_eps = sum[DW-1:0];
  endfunction

endpackage

// File: rtl/lbg_cb_ram.sv
// Codebook storage: flat register array with two write ports, one registered
// read port for the downstream logic and an asynchronous peek port used by
// the split sequencer.
module lbg_cb_ram
  import lbg_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          rd_en,
  input  logic          rd_zero,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic [AW-1:0] peek_addr,
  output logic [DW-1:0] peek_data
);

  logic [DW-1:0] mem [CB_WORDS];

  assign peek_data = mem[peek_addr];

  // Array writes; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wa_en) mem[wa_addr] <= wa_data;
    if (wb_en) mem[wb_addr] <= wb_data;
  end

  // Registered read; sees the array before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/lbg_codebook_split.sv
// Captures the LBG mean vector as codeword 0 and grows the codebook by binary
// splitting, with random-access read and idle-time write ports.
module lbg_codebook_split
  import lbg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] LBG_init,
  input  logic [3:0]           LBG_init_addr,
  input  logic                 LBG_init_en,
  input  logic                 INIT_START,
  output logic                 INIT_DONE,
  input  logic                 SPLIT_START,
  output logic                 SPLIT_FINSH,
  output logic                 ERR,
  output logic                 BUSY,
  output logic [4:0]           CB_SIZE,
  input  logic                 RD_EN,
  input  logic [3:0]           RD_INDEX,
  input  logic [3:0]           RD_DIM,
  output logic signed [DW-1:0] RD_DATA,
  output logic                 RD_VALID,
  input  logic                 WR_EN,
  input  logic [3:0]           WR_INDEX,
  input  logic [3:0]           WR_DIM,
  input  logic signed [DW-1:0] WR_DATA
);

  lbg_state_t state_q, state_d;
  logic [4:0] cb_size_q, cb_size_d;
  logic [4:0] n_q, n_d;
  logic [3:0] k_q, k_d;
  logic [3:0] dim_q, dim_d;
  logic signed [DW-1:0] v_q, v_d;
  logic init_done_q, init_done_d;
  logic finsh_q, finsh_d;
  logic err_q, err_d;
  logic split_ok;

  logic          wa_en, wb_en;
  logic [AW-1:0] wa_addr, wb_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic [DW-1:0] peek_data;
  logic [DW-1:0] rd_data_raw;
  logic          rd_zero;

  assign rd_zero     = (RD_DIM > LAST_DIM) || ({1'b0, RD_INDEX} >= cb_size_q);
  assign BUSY        = (state_q == ST_LOAD) || (state_q == ST_SPLIT_RD) || (state_q == ST_SPLIT_WR);
  assign CB_SIZE     = cb_size_q;
  assign INIT_DONE   = init_done_q;
  assign SPLIT_FINSH = finsh_q;
  assign ERR         = err_q;
  assign RD_DATA     = rd_data_raw;

  lbg_cb_ram u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wa_en     (wa_en),
    .wa_addr   (wa_addr),
    .wa_data   (wa_data),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_en     (RD_EN),
    .rd_zero   (rd_zero),
    .rd_addr   (cb_addr(RD_INDEX, RD_DIM)),
    .rd_data   (rd_data_raw),
    .rd_valid  (RD_VALID),
    .peek_addr (cb_addr(k_q, dim_q)),
    .peek_data (peek_data)
  );

  // Next-state, write-port steering and pulse generation; INIT_START overrides all.
  always_comb begin
    state_d     = state_q;
    cb_size_d   = cb_size_q;
    n_d         = n_q;
    k_d         = k_q;
    dim_d       = dim_q;
    v_d         = v_q;
    init_done_d = 1'b0;
    finsh_d     = 1'b0;
    err_d       = 1'b0;
    wa_en       = 1'b0;
    wa_addr     = '0;
    wa_data     = '0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    split_ok    = (cb_size_q != 5'd0) && (cb_size_q <= 5'(CB_MAX / 2));

    case (state_q)
      ST_IDLE: begin
        if (SPLIT_START && split_ok) begin
          n_d     = cb_size_q;
          k_d     = 4'd0;
          dim_d   = 4'd0;
          state_d = ST_SPLIT_RD;
        end else begin
          err_d = SPLIT_START;
          if (WR_EN && ({1'b0, WR_INDEX} < cb_size_q) && (WR_DIM <= LAST_DIM)) begin
            wa_en   = 1'b1;
            wa_addr = cb_addr(WR_INDEX, WR_DIM);
            wa_data = WR_DATA;
          end
        end
      end
      ST_LOAD: begin
        if (LBG_init_en && (LBG_init_addr <= LAST_DIM)) begin
          wa_en   = 1'b1;
          wa_addr = cb_addr(4'd0, LBG_init_addr);
          wa_data = LBG_init;
          if (LBG_init_addr == LAST_DIM) begin
            cb_size_d   = 5'd1;
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_SPLIT_RD: begin
        v_d     = peek_data;
        state_d = ST_SPLIT_WR;
      end
      ST_SPLIT_WR: begin
        wa_en   = 1'b1;
        wa_addr = cb_addr(k_q, dim_q);
        wa_data = sat_eps(v_q, 1'b1);
        wb_en   = 1'b1;
        wb_addr = cb_addr(k_q + n_q[3:0], dim_q);
        wb_data = sat_eps(v_q, 1'b0);
        if (dim_q == LAST_DIM) begin
          dim_d = 4'd0;
          if (({1'b0, k_q} + 5'd1) == n_q) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = ST_SPLIT_RD;
          end
        end else begin
          dim_d   = dim_q + 4'd1;
          state_d = ST_SPLIT_RD;
        end
      end
      ST_DONE: begin
        cb_size_d = n_q << 1;
        finsh_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (INIT_START) begin
      state_d     = ST_LOAD;
      cb_size_d   = 5'd0;
      init_done_d = 1'b0;
      finsh_d     = 1'b0;
      err_d       = 1'b0;
      wa_en       = 1'b0;
      wb_en       = 1'b0;
    end

    if (!rst_n) begin
      wa_en = 1'b0;
      wb_en = 1'b0;
    end
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cb_size_q   <= 5'd0;
      n_q         <= 5'd0;
      k_q         <= 4'd0;
      dim_q       <= 4'd0;
      v_q         <= '0;
      init_done_q <= 1'b0;
      finsh_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cb_size_q   <= cb_size_d;
      n_q         <= n_d;
      k_q         <= k_d;
      dim_q       <= dim_d;
      v_q         <= v_d;
      init_done_q <= init_done_d;
      finsh_q     <= finsh_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_lbg_codebook_split.sv
// Directed self-checking bench for lbg_codebook_split.
module tb_lbg_codebook_split;
  import lbg_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] LBG_init;
  logic [3:0]           LBG_init_addr;
  logic                 LBG_init_en;
  logic                 INIT_START;
  logic                 INIT_DONE;
  logic                 SPLIT_START;
  logic                 SPLIT_FINSH;
  logic                 ERR;
  logic                 BUSY;
  logic [4:0]           CB_SIZE;
  logic                 RD_EN;
  logic [3:0]           RD_INDEX;
  logic [3:0]           RD_DIM;
  logic signed [DW-1:0] RD_DATA;
  logic                 RD_VALID;
  logic                 WR_EN;
  logic [3:0]           WR_INDEX;
  logic [3:0]           WR_DIM;
  logic signed [DW-1:0] WR_DATA;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [DW-1:0] rd;
  logic                 rv;
  int                   cyc;
  logic signed [DW-1:0] vals [DIM];

  lbg_codebook_split dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .LBG_init      (LBG_init),
    .LBG_init_addr (LBG_init_addr),
    .LBG_init_en   (LBG_init_en),
    .INIT_START    (INIT_START),
    .INIT_DONE     (INIT_DONE),
    .SPLIT_START   (SPLIT_START),
    .SPLIT_FINSH   (SPLIT_FINSH),
    .ERR           (ERR),
    .BUSY          (BUSY),
    .CB_SIZE       (CB_SIZE),
    .RD_EN         (RD_EN),
    .RD_INDEX      (RD_INDEX),
    .RD_DIM        (RD_DIM),
    .RD_DATA       (RD_DATA),
    .RD_VALID      (RD_VALID),
    .WR_EN         (WR_EN),
    .WR_INDEX      (WR_INDEX),
    .WR_DIM        (WR_DIM),
    .WR_DATA       (WR_DATA)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] idx, input logic [3:0] dim,
                         output logic signed [DW-1:0] data, output logic valid);
    RD_EN = 1'b1; RD_INDEX = idx; RD_DIM = dim;
    tick();
    data = RD_DATA; valid = RD_VALID;
    RD_EN = 1'b0;
  endtask

  task automatic load_cw0(input logic signed [DW-1:0] v [DIM]);
    INIT_START = 1'b1;
    tick();
    INIT_START = 1'b0;
    for (int a = 0; a < DIM; a++) begin
      LBG_init_en = 1'b1; LBG_init_addr = 4'(a); LBG_init = v[a];
      tick();
    end
    LBG_init_en = 1'b0;
    tick();
  endtask

  task automatic run_split(output int cycles);
    SPLIT_START = 1'b1;
    tick();
    SPLIT_START = 1'b0;
    cycles = 0;
    while (!SPLIT_FINSH && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if (CB_SIZE !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_cb_size: got %0d expected 0", CB_SIZE); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    n_checks++;
    if ({INIT_DONE, SPLIT_FINSH, ERR, RD_VALID} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {INIT_DONE, SPLIT_FINSH, ERR, RD_VALID});
    end
    n_checks++;
    if (RD_DATA !== '0) begin n_fail++; $display("[TB] FAIL reset_rd_data: got %0d expected 0", RD_DATA); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_err_empty();
    SPLIT_START = 1'b1;
    tick();
    SPLIT_START = 1'b0;
    n_checks++;
    if (ERR !== 1'b1) begin n_fail++; $display("[TB] FAIL err_empty: got %b expected 1", ERR); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL err_empty_busy: got %b expected 0", BUSY); end
    tick();
    n_checks++;
    if (ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL err_empty_pulse: got %b expected 0", ERR); end
  endtask

  task automatic test_load();
    INIT_START = 1'b1;
    tick();
    INIT_START = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1) begin n_fail++; $display("[TB] FAIL load_busy: got %b expected 1", BUSY); end
    LBG_init_en = 1'b1; LBG_init_addr = 4'd13; LBG_init = 14'sd777;
    tick();
    n_checks++;
    if (BUSY !== 1'b1 || INIT_DONE !== 1'b0) begin
      n_fail++; $display("[TB] FAIL load_addr13: got busy=%b done=%b expected busy=1 done=0", BUSY, INIT_DONE);
    end
    for (int a = 0; a < DIM; a++) begin
      LBG_init_en = 1'b1; LBG_init_addr = 4'(a); LBG_init = DW'(100 * a);
      tick();
      if (a == 11) begin
        n_checks++;
        if (INIT_DONE !== 1'b0) begin n_fail++; $display("[TB] FAIL load_early_done: got %b expected 0", INIT_DONE); end
      end
    end
    LBG_init_en = 1'b0;
    n_checks++;
    if (INIT_DONE !== 1'b1) begin n_fail++; $display("[TB] FAIL load_done: got %b expected 1", INIT_DONE); end
    n_checks++;
    if (CB_SIZE !== 5'd1) begin n_fail++; $display("[TB] FAIL load_cb_size: got %0d expected 1", CB_SIZE); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL load_idle: got %b expected 0", BUSY); end
    tick();
    n_checks++;
    if (INIT_DONE !== 1'b0) begin n_fail++; $display("[TB] FAIL load_done_pulse: got %b expected 0", INIT_DONE); end
    do_read(4'd0, 4'd5, rd, rv);
    n_checks++;
    if (rd !== 14'sd500 || rv !== 1'b1) begin n_fail++; $display("[TB] FAIL load_read: got %0d/%b expected 500/1", rd, rv); end
    LBG_init_en = 1'b1; LBG_init_addr = 4'd5; LBG_init = 14'sd4321;
    tick();
    LBG_init_en = 1'b0;
    do_read(4'd0, 4'd5, rd, rv);
    n_checks++;
    if (rd !== 14'sd500) begin n_fail++; $display("[TB] FAIL beat_outside_load: got %0d expected 500", rd); end
  endtask

  task automatic test_split_basic();
    vals = '{default: '0};
    vals[0] = 14'sd1000; vals[1] = -14'sd1000;
    load_cw0(vals);
    SPLIT_START = 1'b1;
    tick();
    SPLIT_START = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1) begin n_fail++; $display("[TB] FAIL split_busy: got %b expected 1", BUSY); end
    cyc = 0;
    while (!SPLIT_FINSH && cyc < 300) begin
      tick();
      cyc++;
      if (cyc == 5) begin
        n_checks++;
        if (BUSY !== 1'b1) begin n_fail++; $display("[TB] FAIL split_busy_mid: got %b expected 1", BUSY); end
        WR_EN = 1'b1; WR_INDEX = 4'd0; WR_DIM = 4'd0; WR_DATA = 14'sd1234;
      end else begin
        WR_EN = 1'b0;
      end
    end
    WR_EN = 1'b0;
    n_checks++;
    if (cyc !== 27) begin n_fail++; $display("[TB] FAIL split_latency: got %0d expected 27", cyc); end
    n_checks++;
    if (CB_SIZE !== 5'd2) begin n_fail++; $display("[TB] FAIL split_cb_size: got %0d expected 2", CB_SIZE); end
    tick();
    n_checks++;
    if (SPLIT_FINSH !== 1'b0) begin n_fail++; $display("[TB] FAIL split_finsh_pulse: got %b expected 0", SPLIT_FINSH); end
    do_read(4'd0, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd1031) begin n_fail++; $display("[TB] FAIL split_c0d0: got %0d expected 1031", rd); end
    do_read(4'd1, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd969) begin n_fail++; $display("[TB] FAIL split_c1d0: got %0d expected 969", rd); end
    do_read(4'd0, 4'd1, rd, rv);
    n_checks++;
    if (rd !== -14'sd1032) begin n_fail++; $display("[TB] FAIL split_c0d1: got %0d expected -1032", rd); end
    do_read(4'd1, 4'd1, rd, rv);
    n_checks++;
    if (rd !== -14'sd968) begin n_fail++; $display("[TB] FAIL split_c1d1: got %0d expected -968", rd); end
    do_read(4'd0, 4'd2, rd, rv);
    n_checks++;
    if (rd !== 14'sd0) begin n_fail++; $display("[TB] FAIL split_c0d2: got %0d expected 0", rd); end
    do_read(4'd1, 4'd2, rd, rv);
    n_checks++;
    if (rd !== 14'sd0) begin n_fail++; $display("[TB] FAIL split_c1d2: got %0d expected 0", rd); end
  endtask

  task automatic test_saturation();
    vals = '{default: '0};
    vals[0] = 14'sd8191; vals[1] = -14'sd8192;
    load_cw0(vals);
    run_split(cyc);
    n_checks++;
    if (cyc !== 27) begin n_fail++; $display("[TB] FAIL sat_latency: got %0d expected 27", cyc); end
    do_read(4'd0, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd8191) begin n_fail++; $display("[TB] FAIL sat_pos_plus: got %0d expected 8191", rd); end
    do_read(4'd1, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd7936) begin n_fail++; $display("[TB] FAIL sat_pos_minus: got %0d expected 7936", rd); end
    do_read(4'd0, 4'd1, rd, rv);
    n_checks++;
    if (rd !== -14'sd8192) begin n_fail++; $display("[TB] FAIL sat_neg_plus: got %0d expected -8192", rd); end
    do_read(4'd1, 4'd1, rd, rv);
    n_checks++;
    if (rd !== -14'sd7936) begin n_fail++; $display("[TB] FAIL sat_neg_minus: got %0d expected -7936", rd); end
  endtask

  task automatic test_split_chain();
    int n;
    vals = '{default: '0};
    vals[0] = 14'sd1024;
    load_cw0(vals);
    for (int s = 0; s < 4; s++) begin
      n = 1 << s;
      run_split(cyc);
      n_checks++;
      if (cyc !== 2 * n * DIM + 1) begin
        n_fail++; $display("[TB] FAIL chain_latency_%0d: got %0d expected %0d", s, cyc, 2 * n * DIM + 1);
      end
      n_checks++;
      if (CB_SIZE !== 5'(2 * n)) begin
        n_fail++; $display("[TB] FAIL chain_size_%0d: got %0d expected %0d", s, CB_SIZE, 2 * n);
      end
    end
    SPLIT_START = 1'b1;
    tick();
    SPLIT_START = 1'b0;
    n_checks++;
    if (ERR !== 1'b1 || BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL chain_err: got err=%b busy=%b expected 1/0", ERR, BUSY); end
    n_checks++;
    if (CB_SIZE !== 5'd16) begin n_fail++; $display("[TB] FAIL chain_full_size: got %0d expected 16", CB_SIZE); end
    tick();
    n_checks++;
    if (ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL chain_err_pulse: got %b expected 0", ERR); end
    do_read(4'd0, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd1158) begin n_fail++; $display("[TB] FAIL chain_c0: got %0d expected 1158", rd); end
    do_read(4'd15, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd902) begin n_fail++; $display("[TB] FAIL chain_c15: got %0d expected 902", rd); end
  endtask

  task automatic test_abort();
    logic seen;
    vals = '{default: '0};
    vals[0] = 14'sd500;
    load_cw0(vals);
    SPLIT_START = 1'b1;
    tick();
    SPLIT_START = 1'b0;
    repeat (9) tick();
    INIT_START = 1'b1;
    tick();
    INIT_START = 1'b0;
    n_checks++;
    if (CB_SIZE !== 5'd0 || BUSY !== 1'b1) begin
      n_fail++; $display("[TB] FAIL abort_state: got size=%0d busy=%b expected 0/1", CB_SIZE, BUSY);
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | SPLIT_FINSH;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_finsh: got %b expected 0", seen); end
    for (int a = 0; a < DIM; a++) begin
      LBG_init_en = 1'b1; LBG_init_addr = 4'(a); LBG_init = DW'(50 * a);
      tick();
    end
    LBG_init_en = 1'b0;
    n_checks++;
    if (INIT_DONE !== 1'b1 || CB_SIZE !== 5'd1) begin
      n_fail++; $display("[TB] FAIL abort_reload: got done=%b size=%0d expected 1/1", INIT_DONE, CB_SIZE);
    end
    tick();
    do_read(4'd0, 4'd3, rd, rv);
    n_checks++;
    if (rd !== 14'sd150) begin n_fail++; $display("[TB] FAIL abort_read: got %0d expected 150", rd); end
  endtask

  task automatic test_reads();
    WR_EN = 1'b1; WR_INDEX = 4'd0; WR_DIM = 4'd4; WR_DATA = -14'sd77;
    tick();
    WR_EN = 1'b0;
    do_read(4'd0, 4'd4, rd, rv);
    n_checks++;
    if (rd !== -14'sd77) begin n_fail++; $display("[TB] FAIL idle_write: got %0d expected -77", rd); end
    WR_EN = 1'b1; WR_DATA = 14'sd55;
    RD_EN = 1'b1; RD_INDEX = 4'd0; RD_DIM = 4'd4;
    tick();
    rd = RD_DATA;
    WR_EN = 1'b0; RD_EN = 1'b0;
    n_checks++;
    if (rd !== -14'sd77) begin n_fail++; $display("[TB] FAIL rd_wr_same: got %0d expected -77", rd); end
    do_read(4'd0, 4'd4, rd, rv);
    n_checks++;
    if (rd !== 14'sd55) begin n_fail++; $display("[TB] FAIL rd_after_wr: got %0d expected 55", rd); end
    WR_EN = 1'b1; WR_INDEX = 4'd0; WR_DIM = 4'd0; WR_DATA = 14'sd4000;
    run_split(cyc);
    WR_EN = 1'b0;
    n_checks++;
    if (cyc !== 27 || CB_SIZE !== 5'd2) begin
      n_fail++; $display("[TB] FAIL wr_split_done: got cyc=%0d size=%0d expected 27/2", cyc, CB_SIZE);
    end
    do_read(4'd0, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd0) begin n_fail++; $display("[TB] FAIL wr_split_drop_c0: got %0d expected 0", rd); end
    do_read(4'd1, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd0) begin n_fail++; $display("[TB] FAIL wr_split_drop_c1: got %0d expected 0", rd); end
    do_read(4'd0, 4'd4, rd, rv);
    n_checks++;
    if (rd !== 14'sd56) begin n_fail++; $display("[TB] FAIL split55_plus: got %0d expected 56", rd); end
    do_read(4'd1, 4'd4, rd, rv);
    n_checks++;
    if (rd !== 14'sd54) begin n_fail++; $display("[TB] FAIL split55_minus: got %0d expected 54", rd); end
    do_read(4'd3, 4'd0, rd, rv);
    n_checks++;
    if (rd !== 14'sd0 || rv !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_index_oob: got %0d/%b expected 0/1", rd, rv); end
    do_read(4'd0, 4'd13, rd, rv);
    n_checks++;
    if (rd !== 14'sd0) begin n_fail++; $display("[TB] FAIL rd_dim_oob: got %0d expected 0", rd); end
    tick();
    n_checks++;
    if (RD_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_valid_drop: got %b expected 0", RD_VALID); end
  endtask

  initial begin
    rst_n = 1'b0; LBG_init = '0; LBG_init_addr = '0; LBG_init_en = 1'b0;
    INIT_START = 1'b0; SPLIT_START = 1'b0;
    RD_EN = 1'b0; RD_INDEX = '0; RD_DIM = '0;
    WR_EN = 1'b0; WR_INDEX = '0; WR_DIM = '0; WR_DATA = '0;
    test_reset();
    test_err_empty();
    test_load();
    test_split_basic();
    test_saturation();
    test_split_chain();
    test_abort();
    test_reads();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
